// File: rtl/apb_timeout_demux_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg : shared types for the registered APB4 timeout demultiplexer.
//   prot_t            - APB4 PPROT field
//   apb_demux_state_e - demux FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   idx_width()       - width of a port index, never narrower than one bit
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef logic [2:0] prot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_demux_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/apb_timeout_demux_addr_decode.sv
// ---------------------------------------------------------------------------
// apb_addr_decode : combinational priority range decoder.
//   addr_i        - address to decode
//   start_addr_i  - per-port inclusive range start
//   end_addr_i    - per-port exclusive range end (start >= end never hits)
//   hit_o         - some range contains addr_i
//   idx_o         - lowest-index port whose range contains addr_i
// ---------------------------------------------------------------------------
module apb_addr_decode #(
    parameter int unsigned NumSlv    = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdxWidth  = 2
) (
    input  logic [AddrWidth-1:0]             addr_i,
    input  logic [NumSlv-1:0][AddrWidth-1:0] start_addr_i,
    input  logic [NumSlv-1:0][AddrWidth-1:0] end_addr_i,
    output logic                             hit_o,
    output logic [IdxWidth-1:0]              idx_o
);

    // Scan from the highest port down so a lower matching port overwrites.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = int'(NumSlv) - 1; i >= 0; i--) begin
            if ((addr_i >= start_addr_i[i]) && (addr_i < end_addr_i[i])) begin
                hit_o = 1'b1;
                idx_o = IdxWidth'(i);
            end else begin
                hit_o = hit_o;
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/apb_timeout_demux.sv
// ---------------------------------------------------------------------------
// apb_timeout_demux : registered APB4 1-to-NumSlv demultiplexer.
// Upstream completer port slv_* is decoded against programmable ranges and
// re-issued as a registered setup/access sequence on mst_*; the response is
// returned upstream one cycle later. Unmapped addresses answer PSLVERR.
//   clk_i, rst_i (async, active-high)
//   start_addr_i/end_addr_i    - per-port address windows [start, end)
//   slv_p*_i / slv_p*_o        - upstream APB4 completer side
//   mst_p*_o / mst_p*_i        - downstream APB4 requester side (one-hot psel)
//   timeout_o                  - one-cycle pulse when an access times out
// Optional build macro APB_TIMEOUT_DEMUX_TIMEOUT_EN: bounds the access phase
// to TimeoutCycles cycles; without it the access phase waits indefinitely
// and timeout_o is tied low.
// ---------------------------------------------------------------------------
module apb_timeout_demux
    import apb_pkg::*;
#(
    parameter int unsigned NumSlv        = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256,
    localparam int unsigned StrbWidth    = (DataWidth + 7) / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumSlv-1:0][AddrWidth-1:0] start_addr_i,
    input  logic [NumSlv-1:0][AddrWidth-1:0] end_addr_i,
    input  logic [AddrWidth-1:0]             slv_paddr_i,
    input  prot_t                            slv_pprot_i,
    input  logic                             slv_pwrite_i,
    input  logic                             slv_psel_i,
    input  logic                             slv_penable_i,
    input  logic [DataWidth-1:0]             slv_pwdata_i,
    input  logic [StrbWidth-1:0]             slv_pstrb_i,
    output logic                             slv_pready_o,
    output logic [DataWidth-1:0]             slv_prdata_o,
    output logic                             slv_pslverr_o,
    output logic [AddrWidth-1:0]             mst_paddr_o,
    output prot_t                            mst_pprot_o,
    output logic                             mst_pwrite_o,
    output logic [DataWidth-1:0]             mst_pwdata_o,
    output logic [StrbWidth-1:0]             mst_pstrb_o,
    output logic [NumSlv-1:0]                mst_psel_o,
    output logic                             mst_penable_o,
    input  logic [NumSlv-1:0]                mst_pready_i,
    input  logic [NumSlv-1:0]                mst_pslverr_i,
    input  logic [NumSlv-1:0][DataWidth-1:0] mst_prdata_i,
    output logic                             timeout_o
);

    localparam int unsigned IdxWidth = idx_width(NumSlv);

    if ((NumSlv < 32'd1) || (TimeoutCycles < 32'd1)) begin : g_param_check
        $error("apb_timeout_demux: NumSlv and TimeoutCycles must be >= 1");
    end

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        prot_t                prot;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] strb;
    } req_t;

    apb_demux_state_e       state_q;
    req_t                   req_d, req_q;
    logic [IdxWidth-1:0]    idx_q;
    logic [IdxWidth-1:0]    dec_idx;
    logic                   dec_hit;
    logic [NumSlv-1:0]      sel_d;
    logic [NumSlv-1:0]      psel_q;
    logic                   penable_q;
    logic                   pready_q;
    logic [DataWidth-1:0]   rdata_q;
    logic                   pslverr_q;

`ifdef APB_TIMEOUT_DEMUX_TIMEOUT_EN
    localparam int unsigned TimerWidth = $clog2(TimeoutCycles + 32'd1);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 32'd1);
    logic [TimerWidth-1:0]  timer_q;
    logic                   timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign req_d = '{addr:  slv_paddr_i,
                     prot:  slv_pprot_i,
                     write: slv_pwrite_i,
                     wdata: slv_pwdata_i,
                     strb:  slv_pstrb_i};

    // Decode the live upstream address; it is only used in the setup cycle.
    apb_addr_decode #(
        .NumSlv    (NumSlv),
        .AddrWidth (AddrWidth),
        .IdxWidth  (IdxWidth)
    ) u_decode (
        .addr_i       (slv_paddr_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .hit_o        (dec_hit),
        .idx_o        (dec_idx)
    );

    // One-hot select for the decoded port.
    always_comb begin
        sel_d          = '0;
        sel_d[dec_idx] = 1'b1;
    end

    // Demux FSM; every output is a register updated here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            idx_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pready_q  <= 1'b0;
            rdata_q   <= '0;
            pslverr_q <= 1'b0;
`ifdef APB_TIMEOUT_DEMUX_TIMEOUT_EN
            timer_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (slv_psel_i && !slv_penable_i) begin
                        req_q <= req_d;
                        idx_q <= dec_idx;
                        if (dec_hit) begin
                            state_q <= SETUP;
                            psel_q  <= sel_d;
                        end else begin
                            // Miss: answer directly with an error, no downstream access.
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            rdata_q   <= '0;
                            pslverr_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
`ifdef APB_TIMEOUT_DEMUX_TIMEOUT_EN
                    timer_q   <= '0;
`endif
                end
                ACCESS: begin
                    // A ready completer wins over a timeout in the same cycle.
                    if (mst_pready_i[idx_q]) begin
                        state_q   <= RESP;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        rdata_q   <= mst_prdata_i[idx_q];
                        pslverr_q <= mst_pslverr_i[idx_q];
                    end
`ifdef APB_TIMEOUT_DEMUX_TIMEOUT_EN
                    else if (timer_q == TimerLast) begin
                        state_q   <= RESP;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        rdata_q   <= '0;
                        pslverr_q <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TimerWidth'(1);
                    end
`else
                    else begin
                        state_q <= ACCESS;
                    end
`endif
                end
                RESP: begin
                    state_q  <= IDLE;
                    pready_q <= 1'b0;
`ifdef APB_TIMEOUT_DEMUX_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    pready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mst_paddr_o   = req_q.addr;
    assign mst_pprot_o   = req_q.prot;
    assign mst_pwrite_o  = req_q.write;
    assign mst_pwdata_o  = req_q.wdata;
    assign mst_pstrb_o   = req_q.strb;
    assign mst_psel_o    = psel_q;
    assign mst_penable_o = penable_q;
    assign slv_pready_o  = pready_q;
    assign slv_prdata_o  = rdata_q;
    assign slv_pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_timeout_demux.sv
// ---------------------------------------------------------------------------
// tb_apb_timeout_demux : self-checking bench for apb_timeout_demux.
// The expected port for each address comes from a plain range lookup over
// the bench's own window tables; expected latency follows the transfer
// timeline (setup T1, access T2, response one cycle after downstream ready).
// ---------------------------------------------------------------------------
module tb_apb_timeout_demux;

    localparam int NS = 4;
    localparam int TO = 4;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic [NS-1:0][31:0] start_a, end_a;
    logic [31:0]        slv_paddr;
    logic [2:0]         slv_pprot;
    logic               slv_pwrite, slv_psel, slv_penable;
    logic [31:0]        slv_pwdata;
    logic [3:0]         slv_pstrb;
    logic               slv_pready, slv_pslverr;
    logic [31:0]        slv_prdata;
    logic [31:0]        mst_paddr, mst_pwdata;
    logic [2:0]         mst_pprot;
    logic               mst_pwrite, mst_penable;
    logic [3:0]         mst_pstrb;
    logic [NS-1:0]      mst_psel;
    logic [NS-1:0]      mst_pready, mst_pslverr;
    logic [NS-1:0][31:0] mst_prdata;
    logic               timeout;

    int checks   = 0;
    int failures = 0;

    apb_timeout_demux #(
        .NumSlv(NS), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .start_addr_i(start_a), .end_addr_i(end_a),
        .slv_paddr_i(slv_paddr), .slv_pprot_i(slv_pprot), .slv_pwrite_i(slv_pwrite),
        .slv_psel_i(slv_psel), .slv_penable_i(slv_penable),
        .slv_pwdata_i(slv_pwdata), .slv_pstrb_i(slv_pstrb),
        .slv_pready_o(slv_pready), .slv_prdata_o(slv_prdata), .slv_pslverr_o(slv_pslverr),
        .mst_paddr_o(mst_paddr), .mst_pprot_o(mst_pprot), .mst_pwrite_o(mst_pwrite),
        .mst_pwdata_o(mst_pwdata), .mst_pstrb_o(mst_pstrb),
        .mst_psel_o(mst_psel), .mst_penable_o(mst_penable),
        .mst_pready_i(mst_pready), .mst_pslverr_i(mst_pslverr), .mst_prdata_i(mst_prdata),
        .timeout_o(timeout)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference decode: first window (lowest index) containing the address.
    function automatic int ref_port(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((start_a[i] <= a) && (a < end_a[i])) return i;
        end
        return -1;
    endfunction

    // One upstream transfer; the target completer becomes ready k cycles into access.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [3:0] strb, input int k, input logic [31:0] rd,
                        input logic err);
        int          p;
        logic [3:0]  exp_sel;
        logic [2:0]  prot;
        p    = ref_port(addr);
        prot = 3'($urandom_range(0, 7));
        slv_psel = 1'b1; slv_penable = 1'b0; slv_paddr = addr; slv_pwrite = wr;
        slv_pwdata = wd; slv_pstrb = strb; slv_pprot = prot;
        // Non-target completers look ready with junk data to expose wrong routing.
        for (int i = 0; i < NS; i++) begin
            mst_pready[i]  = (i != p);
            mst_prdata[i]  = $urandom;
            mst_pslverr[i] = 1'($urandom_range(0, 1));
        end
        tick();                                  // T1
        slv_penable = 1'b1;
        slv_paddr   = $urandom;                  // mid-transfer changes must be ignored
        slv_pwdata  = $urandom;
        slv_pwrite  = ~wr;
        if (p < 0) begin
            chk("miss_pready", slv_pready, 1);
            chk("miss_err", slv_pslverr, 1);
            chk("miss_rdata", slv_prdata, 0);
            chk("miss_sel", mst_psel, 0);
        end else begin
            exp_sel = 4'd1 << p;
            chk("setup_sel", mst_psel, exp_sel);
            chk("setup_en", mst_penable, 0);
            chk("setup_addr", mst_paddr, addr);
            chk("setup_wr", mst_pwrite, wr);
            chk("setup_wdata", mst_pwdata, wd);
            chk("setup_strb", mst_pstrb, strb);
            chk("setup_prot", mst_pprot, prot);
            chk("setup_rdy", slv_pready, 0);
            tick();                              // T2
            for (int c = 0; c < k; c++) begin
                chk("wait_sel", mst_psel, exp_sel);
                chk("wait_en", mst_penable, 1);
                chk("wait_rdy", slv_pready, 0);
                tick();
            end
            chk("acc_sel", mst_psel, exp_sel);
            chk("acc_en", mst_penable, 1);
            chk("acc_addr", mst_paddr, addr);
            mst_pready[p] = 1'b1; mst_prdata[p] = rd; mst_pslverr[p] = err;
            tick();                              // T3+k
            chk("resp_rdy", slv_pready, 1);
            chk("resp_rdata", slv_prdata, rd);
            chk("resp_err", slv_pslverr, err);
            chk("resp_sel", mst_psel, 0);
            chk("resp_en", mst_penable, 0);
            chk("resp_to", timeout, 0);
        end
        tick();
        slv_psel = 1'b0; slv_penable = 1'b0;
        chk("post_rdy", slv_pready, 0);
    endtask

    initial begin
        logic [31:0] bnd [9];
        rst_i = 1'b1;
        slv_psel = 1'b0; slv_penable = 1'b0; slv_paddr = '0; slv_pprot = '0;
        slv_pwrite = 1'b0; slv_pwdata = '0; slv_pstrb = '0;
        mst_pready = '0; mst_pslverr = '0; mst_prdata = '0;
        start_a[0] = 32'h0000_0000; end_a[0] = 32'h0000_1000;
        start_a[1] = 32'h0000_1000; end_a[1] = 32'h0000_2000;
        start_a[2] = 32'h0000_2800; end_a[2] = 32'h0000_4000;
        start_a[3] = 32'h0000_5000; end_a[3] = 32'h0000_5000;   // empty window
        #12;
        chk("rst_sel", mst_psel, 0);
        chk("rst_en", mst_penable, 0);
        chk("rst_rdy", slv_pready, 0);
        chk("rst_rdata", slv_prdata, 0);
        chk("rst_err", slv_pslverr, 0);
        chk("rst_addr", mst_paddr, 0);
        chk("rst_wdata", mst_pwdata, 0);
        chk("rst_to", timeout, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        tick();

        // Directed cases from the transfer timeline.
        xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0BAD_F00D, 1'b0);
        xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 3, 32'h1234_5678, 1'b0);
        xfer(32'h0000_8000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
        xfer(32'h0000_2804, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_0001, 1'b1);

        // Window edges: inclusive start, exclusive end, gaps and the empty window.
        bnd = '{32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000, 32'h27FF,
                32'h2800, 32'h3FFF, 32'h4000, 32'h5000};
        foreach (bnd[i]) xfer(bnd[i], 1'b0, 32'h0, 4'h0, 0, $urandom, 1'b0);

        // Overlap: lowest index wins.
        start_a[0] = 32'h0000_3000; end_a[0] = 32'h0000_3100;
        xfer(32'h0000_3000, 1'b1, 32'h5555_AAAA, 4'h3, 0, 32'h7777_0000, 1'b0);
        start_a[0] = 32'h0000_0000; end_a[0] = 32'h0000_1000;

        // Stalled completer on port1.
        slv_psel = 1'b1; slv_penable = 1'b0; slv_paddr = 32'h0000_1100; slv_pwrite = 1'b0;
        mst_pready = '0;
        tick();
        slv_penable = 1'b1;
        chk("stall_setup_sel", mst_psel, 4'b0010);
        tick();
`ifdef APB_TIMEOUT_DEMUX_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            chk("to_wait_en", mst_penable, 1);
            chk("to_wait_rdy", slv_pready, 0);
            chk("to_wait_to", timeout, 0);
            tick();
        end
        chk("to_rdy", slv_pready, 1);
        chk("to_err", slv_pslverr, 1);
        chk("to_rdata", slv_prdata, 0);
        chk("to_pulse", timeout, 1);
        chk("to_sel", mst_psel, 0);
        tick();
        slv_psel = 1'b0; slv_penable = 1'b0;
        chk("to_pulse_end", timeout, 0);
`else
        for (int c = 0; c < 40; c++) begin
            chk("stall_en", mst_penable, 1);
            chk("stall_sel", mst_psel, 4'b0010);
            chk("stall_rdy", slv_pready, 0);
            tick();
        end
        mst_pready[1] = 1'b1; mst_prdata[1] = 32'hA5A5_5A5A; mst_pslverr[1] = 1'b0;
        tick();
        chk("stall_resp_rdy", slv_pready, 1);
        chk("stall_resp_rdata", slv_prdata, 32'hA5A5_5A5A);
        chk("stall_to", timeout, 0);
        tick();
        slv_psel = 1'b0; slv_penable = 1'b0;
`endif
        tick();

        // Asynchronous reset during access.
        slv_psel = 1'b1; slv_penable = 1'b0; slv_paddr = 32'h0000_0020; mst_pready = '0;
        tick();
        slv_penable = 1'b1;
        tick();
        chk("pre_rst_en", mst_penable, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_sel", mst_psel, 0);
        chk("async_rst_en", mst_penable, 0);
        chk("async_rst_rdy", slv_pready, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        slv_psel = 1'b0; slv_penable = 1'b0;
        tick();
        xfer(32'h0000_0040, 1'b0, 32'h0, 4'h0, 2, 32'h0102_0304, 1'b0);

        // Randomised back-to-back traffic; waits stay below the timeout bound.
        for (int n = 0; n < 30; n++) begin
            xfer(32'($urandom_range(0, 32'h5FFF)), 1'($urandom_range(0, 1)), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, TO - 1), $urandom,
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
